fifo_wr_arbiter: RTL and testbench

//   Round-robin arbiter that shares the single write port of the gray-code fifo among NREQ requesters.

---
 rtl/fifo_wr_arbiter.sv | 80 ++++++++
 tb/tb_fifo_wr_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin owner of the fifo write port: zero-latency word/ack, one idle arbitration cycle per grant.
// Backpressure: fifo_full stalls the holder in place (grant kept, count frozen); non-owners wait for IDLE.
module fifo_wr_arbiter #(
  parameter int NREQ     = 4,
  parameter int DW       = 3,
  parameter int MAXBURST = 4,
  localparam int IW      = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*DW-1:0] data_in,
  input  logic              fifo_full,
  output logic [NREQ-1:0]   ack,
  output logic              wr_en,
  output logic [DW-1:0]     wr_data,
  output logic [IW-1:0]     owner,
  output logic              busy
);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [3:0]      burst_cnt;
  logic [IW-1:0]   next_owner;
  logic [IW-1:0]   idx;
  logic            last_word;

  // Scan from farthest to nearest so the requester closest after rr_ptr wins.
  always_comb begin
    next_owner = rr_ptr;
    idx        = rr_ptr;
    for (int k = NREQ; k >= 1; k--) begin
      idx = rr_ptr + IW'(k);
      if (req[idx]) next_owner = idx;
    end
  end

  assign busy      = (state == XFER);
  assign wr_en     = busy & req[owner] & ~fifo_full;
  assign wr_data   = data_in[owner*DW +: DW];
  assign ack       = wr_en ? (NREQ'(1) << owner) : '0;
  assign last_word = (burst_cnt == 4'(MAXBURST - 1));

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= IW'(NREQ - 1);
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            owner     <= next_owner;
            burst_cnt <= '0;
            state     <= XFER;
          end
        end
        XFER: begin
          if (!req[owner]) begin
            state  <= IDLE;
            rr_ptr <= owner;
          end else if (wr_en) begin
            if (last_word) begin
              state     <= IDLE;
              rr_ptr    <= owner;
              burst_cnt <= '0;
            end else begin
              burst_cnt <= burst_cnt + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: grant-level reference model compared every cycle, plus directed literal checks.
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4;
  localparam int DW = 3;
  localparam int MAXBURST = 4;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*DW-1:0] data_in;
  logic fifo_full = 1'b0;
  logic [NREQ-1:0] ack;
  logic wr_en;
  logic [DW-1:0] wr_data;
  logic [1:0] owner;
  logic busy;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] dval [NREQ] = '{3'd5, 3'd3, 3'd6, 3'd1};
  assign data_in = {dval[3], dval[2], dval[1], dval[0]};

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAXBURST(MAXBURST)) dut (
    .clk(clk), .rstN(rstN), .req(req), .data_in(data_in), .fifo_full(fifo_full),
    .ack(ack), .wr_en(wr_en), .wr_data(wr_data), .owner(owner), .busy(busy)
  );

  // Reference model: who holds the grant, how many words it has delivered, who released last.
  bit m_busy = 1'b0;
  int m_owner = 0;
  int m_last = NREQ - 1;
  int m_words = 0;

  function automatic int pick(input int last, input logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++)
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    return 0;
  endfunction

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      m_busy <= 1'b0; m_owner <= 0; m_last <= NREQ - 1; m_words <= 0;
    end else if (!m_busy) begin
      if (req != '0) begin
        m_owner <= pick(m_last, req); m_busy <= 1'b1; m_words <= 0;
      end
    end else if (!req[m_owner]) begin
      m_busy <= 1'b0; m_last <= m_owner;
    end else if (!fifo_full) begin
      m_words <= m_words + 1;
      if (m_words + 1 == MAXBURST) begin
        m_busy <= 1'b0; m_last <= m_owner;
      end
    end
  end

  int ackcnt [NREQ] = '{0, 0, 0, 0};
  int glog [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    bit pb = 1'b0;
    bit exp_wr;
    forever begin
      @(negedge clk);
      if (rstN) begin
        exp_wr = m_busy && req[m_owner] && !fifo_full;
        check("m_busy", busy, m_busy);
        check("m_wr_en", wr_en, exp_wr);
        check("m_ack", ack, exp_wr ? (32'd1 << m_owner) : 32'd0);
        if (m_busy) begin
          check("m_owner", owner, m_owner);
          check("m_wr_data", wr_data, dval[m_owner]);
        end
        check("ack_onehot", $onehot0(ack), 1);
        check("write_while_full", wr_en && fifo_full, 0);
        for (int i = 0; i < NREQ; i++) if (ack[i]) ackcnt[i]++;
        if (busy && !pb) glog.push_back(int'(owner));
        pb = busy;
      end else begin
        pb = 1'b0;
      end
    end
  endtask

  bit t1_busy [9] = '{0, 1, 1, 1, 1, 0, 1, 1, 0};
  bit t1_wr   [9] = '{0, 1, 1, 1, 1, 0, 1, 0, 0};
  bit t3_busy [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
  bit t3_wr   [9] = '{0, 1, 0, 0, 0, 1, 1, 1, 0};
  logic [3:0] t4_req  [7] = '{4'b0010, 4'b1010, 4'b1010, 4'b1000, 4'b1000, 4'b1000, 4'b0000};
  bit         t4_busy [7] = '{0, 1, 1, 1, 0, 1, 1};
  logic [3:0] t4_ack  [7] = '{4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b1000, 4'b0000};
  int t2_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    int g0;
    int snap [NREQ];
    fork compare_loop(); join_none

    // Reset holds everything quiet even with all requests raised.
    req = 4'b1111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_ack", ack, 0);
    check("rst_owner", owner, 0);
    @(posedge clk); #1;
    rstN = 1'b1;

    // Single requester: 4-word bursts separated by one arbitration bubble.
    for (int c = 0; c <= 8; c++) begin
      req = (c < 7) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      check("t1_busy", busy, t1_busy[c]);
      check("t1_wr_en", wr_en, t1_wr[c]);
      check("t1_ack", ack, t1_wr[c] ? 4'b0001 : 4'b0000);
      check("t1_wr_data", wr_data, 5);
      if (c == 6) check("t1_regrant_owner", owner, 0);
      @(posedge clk); #1;
    end

    // rr_ptr=0 after requester 0: requester 1 is served before 0.
    g0 = glog.size();
    for (int d = 0; d <= 10; d++) begin
      req = (d < 10) ? 4'b0011 : 4'b0000;
      @(negedge clk);
      if (d == 1) begin check("t6_first_owner", owner, 1); check("t6_first_busy", busy, 1); end
      if (d == 2) check("t6_ack_to_1", ack, 4'b0010);
      if (d == 5) check("t6_bubble", busy, 0);
      if (d == 6) begin check("t6_second_owner", owner, 0); check("t6_second_busy", busy, 1); end
      @(posedge clk); #1;
    end
    check("t6_grants", glog.size() - g0, 2);
    if (glog.size() - g0 >= 2) begin
      check("t6_grant0", glog[g0], 1);
      check("t6_grant1", glog[g0 + 1], 0);
    end

    // Asynchronous reset in the middle of requester 1's burst.
    req = 4'b1111;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("t5_owner_before", owner, 1);
    @(posedge clk); #2;
    check("t5_busy_before", busy, 1);
    rstN = 1'b0;
    #1;
    check("t5_busy_async", busy, 0);
    check("t5_wr_en_async", wr_en, 0);
    check("t5_ack_async", ack, 0);
    @(posedge clk); #3;
    rstN = 1'b1;

    // All four requesting after reset: grants 0,1,2,3,0, four words each.
    g0 = glog.size();
    snap = ackcnt;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    req = 4'b0000;
    check("t2_grants", glog.size() - g0, 5);
    if (glog.size() - g0 >= 5)
      for (int k = 0; k < 5; k++) check("t2_order", glog[g0 + k], t2_order[k]);
    check("t2_words0", ackcnt[0] - snap[0], 8);
    check("t2_words1", ackcnt[1] - snap[1], 4);
    check("t2_words2", ackcnt[2] - snap[2], 4);
    check("t2_words3", ackcnt[3] - snap[3], 4);

    // fifo_full on burst cycles 2-4 stalls requester 2 without losing the grant.
    snap = ackcnt;
    for (int c = 0; c <= 8; c++) begin
      req = (c < 8) ? 4'b0100 : 4'b0000;
      fifo_full = (c >= 2 && c <= 4);
      @(negedge clk);
      check("t3_busy", busy, t3_busy[c]);
      check("t3_wr_en", wr_en, t3_wr[c]);
      check("t3_ack", ack, t3_wr[c] ? 4'b0100 : 4'b0000);
      if (c >= 1 && c <= 7) begin
        check("t3_owner", owner, 2);
        check("t3_wr_data", wr_data, 6);
      end
      @(posedge clk); #1;
    end
    fifo_full = 1'b0;
    check("t3_words2", ackcnt[2] - snap[2], 4);

    // Requester 1 drops after two words while 3 waits; 3 gets the next grant.
    snap = ackcnt;
    for (int c = 0; c <= 6; c++) begin
      req = t4_req[c];
      @(negedge clk);
      check("t4_busy", busy, t4_busy[c]);
      check("t4_ack", ack, t4_ack[c]);
      check("t4_wr_en", wr_en, |t4_ack[c]);
      if (c == 5) check("t4_owner", owner, 3);
      @(posedge clk); #1;
    end
    check("t4_words1", ackcnt[1] - snap[1], 2);
    check("t4_words3", ackcnt[3] - snap[3], 1);

    req = 4'b0000;
    repeat (3) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    check("end_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
